// File: rtl/mem_access_serial_tracker_pkg.sv
// Shared sizing and types for the memory access serial tracker.
// Serial widths derive from the outstanding-transaction counts.
package mem_access_serial_tracker_pkg;

    // Index width that stays at least one bit for single-entry pools.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int PHY_ADDR_WIDTH       = 32;
    localparam int MEM_PORT_NUM         = 2;
    localparam int MEM_READ_SERIAL_NUM  = 3;
    localparam int MEM_WRITE_SERIAL_NUM = 2;
    localparam int MEM_LINE_BYTE_NUM    = 8;

    localparam int MEM_ACCESS_SERIAL_WIDTH = idxWidth(MEM_READ_SERIAL_NUM);
    localparam int MEM_WRITE_SERIAL_WIDTH  = idxWidth(MEM_WRITE_SERIAL_NUM);
    localparam int MEM_PORT_INDEX_WIDTH    = idxWidth(MEM_PORT_NUM);
    localparam int MEM_LINE_OFFSET_WIDTH   = $clog2(MEM_LINE_BYTE_NUM);

    typedef logic [MEM_ACCESS_SERIAL_WIDTH-1:0] MemAccessSerial;
    typedef logic [MEM_WRITE_SERIAL_WIDTH-1:0]  MemWriteSerial;
    typedef logic [MEM_PORT_INDEX_WIDTH-1:0]    MemPortIndexPath;

    typedef struct packed {
        logic                                              busy;
        MemPortIndexPath                                   owner;
        logic [PHY_ADDR_WIDTH-MEM_LINE_OFFSET_WIDTH-1:0]   lineAddr;
    } MemSerialEntry;

endpackage

// File: rtl/serial_free_list.sv
// Busy vector for one serial pool: lowest-free picker, alloc/free and a
// registered occupancy count.
module serial_free_list
    import mem_access_serial_tracker_pkg::*;
#(
    parameter int NUM   = MEM_READ_SERIAL_NUM,
    parameter int IDX_W = idxWidth(NUM),
    parameter int CNT_W = $clog2(NUM + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             allocEn,
    input  logic             freeEn,
    input  logic [IDX_W-1:0] freeIdx,
    output logic [NUM-1:0]   busy,
    output logic             freeAvail,
    output logic [IDX_W-1:0] allocIdx,
    output logic             freeHit,
    output logic [CNT_W-1:0] count
);

    logic [NUM-1:0] allocMask;
    logic [NUM-1:0] freeMask;
    logic           allocDo;

    // Descending scan so the lowest free index wins.
    always_comb begin
        freeAvail = 1'b0;
        allocIdx  = '0;
        for (int i = NUM - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                freeAvail = 1'b1;
                allocIdx  = IDX_W'(i);
            end
        end
    end

    assign allocDo = allocEn & freeAvail;

    // Frees of idle or out-of-range serials are dropped and reported via freeHit.
    always_comb begin
        allocMask = '0;
        freeMask  = '0;
        freeHit   = 1'b0;
        for (int i = 0; i < NUM; i++) begin
            if (allocDo && allocIdx == IDX_W'(i)) begin
                allocMask[i] = 1'b1;
            end
            if (freeEn && freeIdx == IDX_W'(i) && busy[i]) begin
                freeMask[i] = 1'b1;
                freeHit     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            busy  <= '0;
            count <= '0;
        end else begin
            busy  <= (busy | allocMask) & ~freeMask;
            count <= count + CNT_W'(allocDo) - CNT_W'(freeHit);
        end
    end

endmodule

// File: rtl/mem_access_serial_tracker.sv
// Arbitrates line requests from cache channels, hands out read/write serials,
// routes read results back to their owner and stalls same-line hazards.
module mem_access_serial_tracker
    import mem_access_serial_tracker_pkg::*;
#(
    parameter  int PORT_NUM         = MEM_PORT_NUM,
    parameter  int READ_SERIAL_NUM  = MEM_READ_SERIAL_NUM,
    parameter  int WRITE_SERIAL_NUM = MEM_WRITE_SERIAL_NUM,
    parameter  int ADDR_WIDTH       = PHY_ADDR_WIDTH,
    parameter  int LINE_BYTE_NUM    = MEM_LINE_BYTE_NUM,
    localparam int RS_W   = idxWidth(READ_SERIAL_NUM),
    localparam int WS_W   = idxWidth(WRITE_SERIAL_NUM),
    localparam int PI_W   = idxWidth(PORT_NUM),
    localparam int RC_W   = $clog2(READ_SERIAL_NUM + 1),
    localparam int WC_W   = $clog2(WRITE_SERIAL_NUM + 1),
    localparam int LINE_W = LINE_BYTE_NUM * 8,
    localparam int OFF_W  = $clog2(LINE_BYTE_NUM),
    localparam int LA_W   = ADDR_WIDTH - OFF_W
) (
    input  logic                               clk,
    input  logic                               rstN,
    input  logic [PORT_NUM-1:0]                reqValid,
    input  logic [PORT_NUM-1:0]                reqWE,
    input  logic [PORT_NUM-1:0][ADDR_WIDTH-1:0] reqAddr,
    input  logic [PORT_NUM-1:0][LINE_W-1:0]    reqData,
    output logic [PORT_NUM-1:0]                reqAck,
    output logic [RS_W-1:0]                    reqSerial,
    output logic [WS_W-1:0]                    reqWSerial,
    output logic                               memReqValid,
    output logic                               memReqWE,
    output logic [ADDR_WIDTH-1:0]              memReqAddr,
    output logic [LINE_W-1:0]                  memReqData,
    output logic [RS_W-1:0]                    memReqSerial,
    output logic [WS_W-1:0]                    memReqWSerial,
    input  logic                               memReqReady,
    input  logic                               memReadValid,
    input  logic [RS_W-1:0]                    memReadSerial,
    input  logic [LINE_W-1:0]                  memReadData,
    input  logic                               memWriteRespValid,
    input  logic [WS_W-1:0]                    memWriteRespSerial,
    output logic [PORT_NUM-1:0]                resultValid,
    output logic [RS_W-1:0]                    resultSerial,
    output logic [LINE_W-1:0]                  resultData,
    output logic [RC_W-1:0]                    readBusyCount,
    output logic [WC_W-1:0]                    writeBusyCount,
    output logic                               protocolError
);

    logic [READ_SERIAL_NUM-1:0]  rBusy;
    logic [WRITE_SERIAL_NUM-1:0] wBusy;
    logic                        rFreeAvail, wFreeAvail;
    logic                        rFreeHit, wFreeHit;
    logic [RS_W-1:0]             rAllocIdx;
    logic [WS_W-1:0]             wAllocIdx;
    logic                        rAllocEn, wAllocEn;

    logic [LA_W-1:0]             rLine  [READ_SERIAL_NUM];
    logic [PI_W-1:0]             rOwner [READ_SERIAL_NUM];
    logic [LA_W-1:0]             wLine  [WRITE_SERIAL_NUM];

    logic [PI_W-1:0]             ptr;
    logic [PORT_NUM-1:0]         hazard;
    logic [PORT_NUM-1:0]         eligible;
    logic                        grantValid;
    logic [PI_W-1:0]             grantIdx;
    logic                        accept;
    logic [PI_W-1:0]             ownerSel;

    serial_free_list #(
        .NUM   (READ_SERIAL_NUM),
        .IDX_W (RS_W),
        .CNT_W (RC_W)
    ) readList (
        .clk       (clk),
        .rstN      (rstN),
        .allocEn   (rAllocEn),
        .freeEn    (memReadValid),
        .freeIdx   (memReadSerial),
        .busy      (rBusy),
        .freeAvail (rFreeAvail),
        .allocIdx  (rAllocIdx),
        .freeHit   (rFreeHit),
        .count     (readBusyCount)
    );

    serial_free_list #(
        .NUM   (WRITE_SERIAL_NUM),
        .IDX_W (WS_W),
        .CNT_W (WC_W)
    ) writeList (
        .clk       (clk),
        .rstN      (rstN),
        .allocEn   (wAllocEn),
        .freeEn    (memWriteRespValid),
        .freeIdx   (memWriteRespSerial),
        .busy      (wBusy),
        .freeAvail (wFreeAvail),
        .allocIdx  (wAllocIdx),
        .freeHit   (wFreeHit),
        .count     (writeBusyCount)
    );

    // Reads wait on pending writes to the same line; writes wait on any access to it.
    always_comb begin
        hazard   = '0;
        eligible = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            for (int w = 0; w < WRITE_SERIAL_NUM; w++) begin
                if (wBusy[w] && wLine[w] == reqAddr[p][ADDR_WIDTH-1:OFF_W]) begin
                    hazard[p] = 1'b1;
                end
            end
            for (int r = 0; r < READ_SERIAL_NUM; r++) begin
                if (reqWE[p] && rBusy[r] && rLine[r] == reqAddr[p][ADDR_WIDTH-1:OFF_W]) begin
                    hazard[p] = 1'b1;
                end
            end
            eligible[p] = rstN && reqValid[p] && !hazard[p] &&
                          (reqWE[p] ? wFreeAvail : rFreeAvail);
        end
    end

    // Descending scan from the pointer leaves the first eligible port at or after it.
    always_comb begin
        int cand;
        grantValid = 1'b0;
        grantIdx   = '0;
        for (int i = PORT_NUM - 1; i >= 0; i--) begin
            cand = (int'(ptr) + i) % PORT_NUM;
            if (eligible[cand]) begin
                grantValid = 1'b1;
                grantIdx   = PI_W'(cand);
            end
        end
    end

    assign memReqValid   = grantValid;
    assign memReqWE      = reqWE[grantIdx];
    assign memReqAddr    = reqAddr[grantIdx];
    assign memReqData    = reqData[grantIdx];
    assign memReqSerial  = rAllocIdx;
    assign memReqWSerial = wAllocIdx;
    assign reqSerial     = rAllocIdx;
    assign reqWSerial    = wAllocIdx;

    assign accept   = grantValid & memReqReady;
    assign rAllocEn = accept & ~memReqWE;
    assign wAllocEn = accept & memReqWE;

    always_comb begin
        reqAck = '0;
        if (accept) begin
            reqAck[grantIdx] = 1'b1;
        end
    end

    // Results for idle serials are swallowed here and flagged as protocol errors.
    always_comb begin
        ownerSel    = '0;
        resultValid = '0;
        for (int r = 0; r < READ_SERIAL_NUM; r++) begin
            if (memReadSerial == RS_W'(r)) begin
                ownerSel = rOwner[r];
            end
        end
        if (rFreeHit) begin
            resultValid[ownerSel] = 1'b1;
        end
    end

    assign resultSerial = memReadSerial;
    assign resultData   = memReadData;

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ptr           <= '0;
            protocolError <= 1'b0;
            for (int r = 0; r < READ_SERIAL_NUM; r++) begin
                rLine[r]  <= '0;
                rOwner[r] <= '0;
            end
            for (int w = 0; w < WRITE_SERIAL_NUM; w++) begin
                wLine[w] <= '0;
            end
        end else begin
            if (accept) begin
                ptr <= (grantIdx == PI_W'(PORT_NUM - 1)) ? '0 : grantIdx + PI_W'(1);
            end
            for (int r = 0; r < READ_SERIAL_NUM; r++) begin
                if (rAllocEn && rAllocIdx == RS_W'(r)) begin
                    rLine[r]  <= memReqAddr[ADDR_WIDTH-1:OFF_W];
                    rOwner[r] <= grantIdx;
                end
            end
            for (int w = 0; w < WRITE_SERIAL_NUM; w++) begin
                if (wAllocEn && wAllocIdx == WS_W'(w)) begin
                    wLine[w] <= memReqAddr[ADDR_WIDTH-1:OFF_W];
                end
            end
            if ((memReadValid && !rFreeHit) || (memWriteRespValid && !wFreeHit)) begin
                protocolError <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_serial_tracker.sv
// Directed bench for mem_access_serial_tracker with hand-computed expectations.
module tb_mem_access_serial_tracker;

    logic             clk = 1'b0;
    logic             rstN;
    logic [1:0]       reqValid, reqWE, reqAck;
    logic [1:0][31:0] reqAddr;
    logic [1:0][63:0] reqData;
    logic [1:0]       reqSerial;
    logic             reqWSerial;
    logic             memReqValid, memReqWE, memReqReady;
    logic [31:0]      memReqAddr;
    logic [63:0]      memReqData;
    logic [1:0]       memReqSerial;
    logic             memReqWSerial;
    logic             memReadValid;
    logic [1:0]       memReadSerial;
    logic [63:0]      memReadData;
    logic             memWriteRespValid;
    logic             memWriteRespSerial;
    logic [1:0]       resultValid;
    logic [1:0]       resultSerial;
    logic [63:0]      resultData;
    logic [1:0]       readBusyCount, writeBusyCount;
    logic             protocolError;

    int errors = 0;
    int checks = 0;

    mem_access_serial_tracker dut (
        .clk                (clk),
        .rstN               (rstN),
        .reqValid           (reqValid),
        .reqWE              (reqWE),
        .reqAddr            (reqAddr),
        .reqData            (reqData),
        .reqAck             (reqAck),
        .reqSerial          (reqSerial),
        .reqWSerial         (reqWSerial),
        .memReqValid        (memReqValid),
        .memReqWE           (memReqWE),
        .memReqAddr         (memReqAddr),
        .memReqData         (memReqData),
        .memReqSerial       (memReqSerial),
        .memReqWSerial      (memReqWSerial),
        .memReqReady        (memReqReady),
        .memReadValid       (memReadValid),
        .memReadSerial      (memReadSerial),
        .memReadData        (memReadData),
        .memWriteRespValid  (memWriteRespValid),
        .memWriteRespSerial (memWriteRespSerial),
        .resultValid        (resultValid),
        .resultSerial       (resultSerial),
        .resultData         (resultData),
        .readBusyCount      (readBusyCount),
        .writeBusyCount     (writeBusyCount),
        .protocolError      (protocolError)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] we,
                                 input logic [31:0] addr0, input logic [31:0] addr1);
        reqValid   = valid;
        reqWE      = we;
        reqAddr[0] = addr0;
        reqAddr[1] = addr1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rstN               = 1'b1;
        reqData[0]         = 64'h0000_0000_AAAA_0000;
        reqData[1]         = 64'h1111_2222_3333_4444;
        applyStimulus(2'b01, 2'b00, 32'h0, 32'h0);
        memReqReady        = 1'b1;
        memReadValid       = 1'b0;
        memReadSerial      = '0;
        memReadData        = '0;
        memWriteRespValid  = 1'b0;
        memWriteRespSerial = 1'b0;
        #1 rstN = 1'b0;
        #2;
        checkOutput("reset_memReqValid", memReqValid, 0);
        checkOutput("reset_reqAck", reqAck, 0);
        checkOutput("reset_readCount", readBusyCount, 0);
        checkOutput("reset_writeCount", writeBusyCount, 0);
        checkOutput("reset_protErr", protocolError, 0);
        checkOutput("reset_resultValid", resultValid, 0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
        step();

        // Single read on port 1, then its result
        applyStimulus(2'b10, 2'b00, 32'h0, 32'h1000);
        #1;
        checkOutput("t1_reqAck", reqAck, 2'b10);
        checkOutput("t1_reqSerial", reqSerial, 0);
        checkOutput("t1_memReqAddr", memReqAddr, 32'h1000);
        checkOutput("t1_memReqWE", memReqWE, 0);
        step();
        checkOutput("t1_readCount", readBusyCount, 1);
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
        memReadValid  = 1'b1;
        memReadSerial = 2'd0;
        memReadData   = 64'hDEAD_BEEF_0123_4567;
        #1;
        checkOutput("t1_resultValid", resultValid, 2'b10);
        checkOutput("t1_resultData", resultData, 64'hDEAD_BEEF_0123_4567);
        step();
        memReadValid = 1'b0;
        checkOutput("t1_readCountFreed", readBusyCount, 0);
        checkOutput("t1_protErr", protocolError, 0);

        // Continuous reads on both ports: round-robin until the pool is full
        applyStimulus(2'b11, 2'b00, 32'h3000, 32'h4000);
        #1;
        checkOutput("t2_ack0", reqAck, 2'b01);
        checkOutput("t2_serial0", reqSerial, 0);
        step();
        #1;
        checkOutput("t2_ack1", reqAck, 2'b10);
        checkOutput("t2_serial1", reqSerial, 1);
        step();
        #1;
        checkOutput("t2_ack2", reqAck, 2'b01);
        checkOutput("t2_serial2", reqSerial, 2);
        step();
        #1;
        checkOutput("t2_stallAck", reqAck, 2'b00);
        checkOutput("t2_stallValid", memReqValid, 0);
        checkOutput("t2_fullCount", readBusyCount, 3);
        memReadValid  = 1'b1;
        memReadSerial = 2'd1;
        #1;
        checkOutput("t2_free1Result", resultValid, 2'b10);
        checkOutput("t2_noSameCycleRealloc", reqAck, 2'b00);
        step();
        memReadValid = 1'b0;
        #1;
        checkOutput("t2_regrantAck", reqAck, 2'b10);
        checkOutput("t2_regrantSerial", reqSerial, 1);
        step();
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
        checkOutput("t2_countAfterRegrant", readBusyCount, 3);
        memReadValid  = 1'b1;
        memReadSerial = 2'd0;
        #1;
        checkOutput("t2_drain0", resultValid, 2'b01);
        step();
        memReadSerial = 2'd1;
        #1;
        checkOutput("t2_drain1", resultValid, 2'b10);
        step();
        memReadSerial = 2'd2;
        #1;
        checkOutput("t2_drain2", resultValid, 2'b01);
        step();
        memReadValid = 1'b0;
        checkOutput("t2_drainedCount", readBusyCount, 0);

        // Write outstanding blocks a same-line read until its response
        applyStimulus(2'b10, 2'b10, 32'h0, 32'h2000);
        #1;
        checkOutput("t3_wAck", reqAck, 2'b10);
        checkOutput("t3_wSerial", reqWSerial, 0);
        checkOutput("t3_memReqWE", memReqWE, 1);
        checkOutput("t3_memReqData", memReqData, 64'h1111_2222_3333_4444);
        step();
        checkOutput("t3_writeCount", writeBusyCount, 1);
        applyStimulus(2'b01, 2'b00, 32'h2004, 32'h0);
        #1;
        checkOutput("t3_rawStall", reqAck, 2'b00);
        step();
        memWriteRespValid  = 1'b1;
        memWriteRespSerial = 1'b0;
        #1;
        checkOutput("t3_stallDuringResp", reqAck, 2'b00);
        step();
        memWriteRespValid = 1'b0;
        checkOutput("t3_writeCountFreed", writeBusyCount, 0);
        #1;
        checkOutput("t3_unblockedAck", reqAck, 2'b01);
        checkOutput("t3_unblockedSerial", reqSerial, 0);
        checkOutput("t3_unblockedAddr", memReqAddr, 32'h2004);
        step();
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
        checkOutput("t3_readCount", readBusyCount, 1);
        memReadValid  = 1'b1;
        memReadSerial = 2'd0;
        #1;
        checkOutput("t3_result", resultValid, 2'b01);
        step();
        memReadValid = 1'b0;

        // Write pool fills; a read on the other port still proceeds
        applyStimulus(2'b10, 2'b10, 32'h0, 32'h5000);
        #1;
        checkOutput("t4_wAck0", reqAck, 2'b10);
        checkOutput("t4_wSerial0", reqWSerial, 0);
        step();
        applyStimulus(2'b10, 2'b10, 32'h0, 32'h6000);
        #1;
        checkOutput("t4_wAck1", reqAck, 2'b10);
        checkOutput("t4_wSerial1", reqWSerial, 1);
        step();
        checkOutput("t4_writeCountFull", writeBusyCount, 2);
        applyStimulus(2'b10, 2'b10, 32'h0, 32'h7000);
        #1;
        checkOutput("t4_wFullStall", reqAck, 2'b00);
        step();
        applyStimulus(2'b11, 2'b10, 32'h8000, 32'h7000);
        #1;
        checkOutput("t4_readPasses", reqAck, 2'b01);
        checkOutput("t4_readSerial", reqSerial, 0);
        checkOutput("t4_readWE", memReqWE, 0);
        step();
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
        checkOutput("t4_readCount", readBusyCount, 1);
        checkOutput("t4_writeCount", writeBusyCount, 2);
        memWriteRespValid  = 1'b1;
        memWriteRespSerial = 1'b0;
        memReadValid       = 1'b1;
        memReadSerial      = 2'd0;
        #1;
        checkOutput("t4_result", resultValid, 2'b01);
        step();
        memReadValid       = 1'b0;
        memWriteRespSerial = 1'b1;
        step();
        memWriteRespValid = 1'b0;
        checkOutput("t4_writeDrained", writeBusyCount, 0);
        checkOutput("t4_readDrained", readBusyCount, 0);
        checkOutput("t4_protErr", protocolError, 0);

        // Result for an unallocated serial
        memReadValid  = 1'b1;
        memReadSerial = 2'd1;
        #1;
        checkOutput("t5_noResult", resultValid, 2'b00);
        step();
        memReadValid = 1'b0;
        checkOutput("t5_protErrSet", protocolError, 1);
        step();
        checkOutput("t5_protErrSticky", protocolError, 1);

        // Asynchronous reset with two reads outstanding
        applyStimulus(2'b10, 2'b00, 32'h0, 32'h9000);
        #1;
        checkOutput("t6_ack0", reqAck, 2'b10);
        checkOutput("t6_serial0", reqSerial, 0);
        step();
        applyStimulus(2'b01, 2'b00, 32'hA000, 32'h0);
        #1;
        checkOutput("t6_ack1", reqAck, 2'b01);
        checkOutput("t6_serial1", reqSerial, 1);
        step();
        checkOutput("t6_readCount", readBusyCount, 2);
        applyStimulus(2'b10, 2'b00, 32'h0, 32'h9000);
        #2 rstN = 1'b0;
        #1;
        checkOutput("t6_rstCount", readBusyCount, 0);
        checkOutput("t6_rstMemReqValid", memReqValid, 0);
        checkOutput("t6_rstReqAck", reqAck, 2'b00);
        checkOutput("t6_rstProtErr", protocolError, 0);
        step();
        rstN = 1'b1;
        #1;
        checkOutput("t6_postAck", reqAck, 2'b10);
        checkOutput("t6_postSerial", reqSerial, 0);
        step();
        applyStimulus(2'b00, 2'b00, 32'h0, 32'h0);
        checkOutput("t6_postCount", readBusyCount, 1);
        memReadValid  = 1'b1;
        memReadSerial = 2'd1;
        #1;
        checkOutput("t6_lateNoResult", resultValid, 2'b00);
        step();
        memReadValid = 1'b0;
        checkOutput("t6_lateProtErr", protocolError, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
